hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It decides every cycle whether to stall or flush the PC, IF/ID, ID/EX and EX/MEM registers. Inputs are load-use hazards, taken branches/jumps resolved in EX, multi-cycle MDU ops and data-memory wait states. It also keeps stall/flush performance counters and a memory-timeout error flag. It drives the new hold/flush enables of the ID/EX register; ID/EX flush semantics are unchanged (all fields zeroed, i.e. a bubble).

Parameters:
MEM_TIMEOUT, 64, max cycles a data-memory request may wait for ack before mem_err sets
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
id_rs1  in  5  source reg 1 of instr in ID
id_rs2  in  5  source reg 2 of instr in ID
id_use_rs1  in  1  ID instr reads rs1
id_use_rs2  in  1  ID instr reads rs2
ex_rd  in  5  dest reg of instr in EX
ex_mem_read  in  1  EX instr is a load
ex_br_taken  in  1  EX resolved taken branch/jump (redirect)
ex_mdu_start  in  1  EX instr is mul/div, first EX cycle
mdu_done  in  1  MDU result valid this cycle
mem_req  in  1  MEM-stage data access active
mem_ack  in  1  data memory completes access this cycle
pc_hold  out  1  PC keeps value
if_id_hold  out  1  IF/ID keeps value
if_id_flush  out  1  IF/ID loads bubble
id_ex_hold  out  1  ID/EX keeps value
id_ex_flush  out  1  ID/EX loads bubble
ex_mem_hold  out  1  EX/MEM keeps value
mem_wb_flush  out  1  MEM/WB loads bubble
stall_cnt  out  CNT_W  cycles with pc_hold=1
flush_cnt  out  CNT_W  redirect events
mem_err  out  1  sticky memory timeout

Behaviour:
- FSM states: RUN, MDU_WAIT, MEM_WAIT. Reset -> RUN; counters 0; mem_err 0; timeout counter 0. All control outputs are combinational from state+inputs and must be 0 in the reset cycle and the cycle after.
- Priority, highest first: MEM wait > MDU wait > redirect > load-use.
- MEM wait: mem_req && !mem_ack, or state MEM_WAIT && !mem_ack -> pc_hold, if_id_hold, id_ex_hold, ex_mem_hold = 1; mem_wb_flush = 1. Enter/stay MEM_WAIT. When mem_ack=1, go to RUN and assert no MEM holds that cycle. A single-cycle ack (mem_req && mem_ack in RUN) causes no stall.
- Timeout: counter increments each MEM_WAIT cycle and clears on leaving MEM_WAIT. When it reaches MEM_TIMEOUT-1 with no ack, mem_err sets (sticky until rst) and the FSM forces a return to RUN, releasing the pipeline.
- MDU: ex_mdu_start && !mdu_done in RUN -> pc_hold, if_id_hold, id_ex_hold = 1; go to MDU_WAIT. The hold persists until the cycle mdu_done=1, then go to RUN with no hold. While held, EX/MEM receives a bubble: ex_mem_hold=0, and MEM-stage logic gates the write using !id_ex_hold.
- Redirect: ex_br_taken && EX not held -> if_id_flush = id_ex_flush = 1, no holds. flush_cnt +1. If EX is held, the redirect is deferred to the release cycle; ex_br_taken stays stable because ID/EX is held.
- Load-use: ex_mem_read && ex_rd != 0 && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd)) -> pc_hold, if_id_hold, id_ex_flush = 1 for exactly one cycle. Suppressed by a redirect in the same cycle (the flush wins).
- hold and flush never both 1 for the same register.
- stall_cnt increments every cycle pc_hold=1. Both counters wrap modulo 2^CNT_W.
- rst asserted mid-MEM_WAIT or MDU_WAIT -> RUN next cycle; pending waits are abandoned.

Decomposition:
- Shared package core_pkg: FSM state enum (RUN/MDU_WAIT/MEM_WAIT), REG_ZERO = 5'd0.
- One natural sub-module: hazard_ldu_detect, the combinational load-use compare.
- Counters and the FSM stay inline.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> pc_hold=if_id_hold=id_ex_flush=1 for 1 cycle; stall_cnt 0->1. Same with ex_rd=0 -> no stall.
- Redirect: ex_br_taken=1 alone -> if_id_flush=id_ex_flush=1, flush_cnt=1. Redirect plus load-use match in the same cycle -> flushes only, no hold.
- MDU: ex_mdu_start=1, mdu_done after 4 cycles -> pc_hold high exactly 4 cycles, state MDU_WAIT, release on the done cycle; stall_cnt=4.
- MEM: mem_req=1, ack after 3 cycles -> ex_mem_hold=1 and mem_wb_flush=1 for 3 cycles, then RUN. mem_req with same-cycle ack -> no hold.
- Timeout: MEM_TIMEOUT=8, never ack -> mem_err=1 after 8 wait cycles, FSM in RUN; mem_err stays 1 until rst.
- Reset mid-MDU_WAIT: rst=1 -> next cycle all outputs 0, counters 0, state RUN.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module  : core_pkg
// Desc    : Shared types and constants for the 5-stage core control logic.
// Rev     : 1.0 - initial release
// ============================================================================
package core_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MDU_WAIT = 2'd1,
      ST_MEM_WAIT = 2'd2
   } hz_state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage
`default_nettype wire

// File: rtl/hazard_ldu_detect.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ldu_detect
// Desc    : Load-use compare between the load in EX and the sources read in ID.
// Rev     : 1.0 - initial release
// ============================================================================
module hazard_ldu_detect
   import core_pkg::*;
(
   input  logic       i_ex_mem_read,
   input  logic [4:0] i_ex_rd,
   input  logic [4:0] i_id_rs1,
   input  logic [4:0] i_id_rs2,
   input  logic       i_id_use_rs1,
   input  logic       i_id_use_rs2,
   output logic       o_ldu_hit
);

   logic w_rs1_hit;
   logic w_rs2_hit;

   assign w_rs1_hit = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
   assign w_rs2_hit = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);

   // x0 never carries a real dependency
   assign o_ldu_hit = i_ex_mem_read && (i_ex_rd != REG_ZERO) && (w_rs1_hit || w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl
// Desc    : Pipeline stall/flush sequencer with perf counters and memory timeout.
// Rev     : 1.0 - initial release
// ============================================================================
module hazard_ctrl
   import core_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_br_taken,
   input  logic             ex_mdu_start,
   input  logic             mdu_done,
   input  logic             mem_req,
   input  logic             mem_ack,
   output logic             pc_hold,
   output logic             if_id_hold,
   output logic             if_id_flush,
   output logic             id_ex_hold,
   output logic             id_ex_flush,
   output logic             ex_mem_hold,
   output logic             mem_wb_flush,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             mem_err
);

   localparam int              TO_W      = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TO_W-1:0] c_to_last = TO_W'(MEM_TIMEOUT - 1);

   hz_state_t        r_state;
   hz_state_t        w_state_nxt;
   logic [TO_W-1:0]  r_to_cnt;
   logic             r_rst_d;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic             r_mem_err;

   logic w_live;
   logic w_to_hit;
   logic w_mem_wait;
   logic w_mdu_wait;
   logic w_ex_held;
   logic w_redirect;
   logic w_ldu_hit;
   logic w_ldu_stall;
   logic w_pc_hold;

   hazard_ldu_detect u_ldu (
      .i_ex_mem_read (ex_mem_read),
      .i_ex_rd       (ex_rd),
      .i_id_rs1      (id_rs1),
      .i_id_rs2      (id_rs2),
      .i_id_use_rs1  (id_use_rs1),
      .i_id_use_rs2  (id_use_rs2),
      .o_ldu_hit     (w_ldu_hit)
   );

   // Controls stay quiet in the reset cycle and the one after it
   assign w_live   = !rst && !r_rst_d;
   assign w_to_hit = (r_state == ST_MEM_WAIT) && !mem_ack && (r_to_cnt == c_to_last);

   // A timeout behaves like a forced ack: the wait ends and lower priorities apply
   assign w_mem_wait = w_live && !mem_ack &&
                       (((r_state == ST_MEM_WAIT) && !w_to_hit) ||
                        ((r_state == ST_RUN) && mem_req));
   assign w_mdu_wait = w_live && !w_mem_wait && !mdu_done &&
                       ((r_state == ST_MDU_WAIT) || ex_mdu_start);

   assign w_ex_held   = w_mem_wait || w_mdu_wait;
   assign w_redirect  = w_live && ex_br_taken && !w_ex_held;
   assign w_ldu_stall = w_live && w_ldu_hit && !w_ex_held && !w_redirect;
   assign w_pc_hold   = w_ex_held || w_ldu_stall;

   always_comb begin
      w_state_nxt = ST_RUN;
      if (w_mem_wait)
         w_state_nxt = ST_MEM_WAIT;
      else if (w_mdu_wait)
         w_state_nxt = ST_MDU_WAIT;
   end

   always_ff @(posedge clk) begin
      r_rst_d <= rst;
      if (rst) begin
         r_state     <= ST_RUN;
         r_to_cnt    <= '0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
         r_mem_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == ST_MEM_WAIT) && (w_state_nxt == ST_MEM_WAIT))
            r_to_cnt <= r_to_cnt + TO_W'(1);
         else
            r_to_cnt <= '0;
         if (w_pc_hold)
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_redirect)
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         if (w_live && w_to_hit)
            r_mem_err <= 1'b1;
      end
   end

   assign pc_hold      = w_pc_hold;
   assign if_id_hold   = w_pc_hold;
   assign if_id_flush  = w_redirect;
   assign id_ex_hold   = w_ex_held;
   assign id_ex_flush  = w_redirect || w_ldu_stall;
   assign ex_mem_hold  = w_mem_wait;
   assign mem_wb_flush = w_mem_wait;
   assign stall_cnt    = r_stall_cnt;
   assign flush_cnt    = r_flush_cnt;
   assign mem_err      = r_mem_err;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_ctrl
// Desc    : Vector table, directed corner sequences and random run vs a model.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

   localparam int TO = 8;
   localparam int CW = 8;

   typedef struct {
      logic       rst;
      logic [4:0] id_rs1;
      logic [4:0] id_rs2;
      logic       id_use_rs1;
      logic       id_use_rs2;
      logic [4:0] ex_rd;
      logic       ex_mem_read;
      logic       ex_br_taken;
      logic       ex_mdu_start;
      logic       mdu_done;
      logic       mem_req;
      logic       mem_ack;
   } stim_t;

   typedef struct {
      stim_t      s;
      logic [6:0] ctl;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    id_rs1, id_rs2, ex_rd;
   logic          id_use_rs1, id_use_rs2, ex_mem_read, ex_br_taken;
   logic          ex_mdu_start, mdu_done, mem_req, mem_ack;
   logic          pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush;
   logic          ex_mem_hold, mem_wb_flush, mem_err;
   logic [CW-1:0] stall_cnt, flush_cnt;
   logic [6:0]    ctl;
   logic [6:0]    seen;

   int total = 0;
   int bad   = 0;

   // Reference model state
   bit         m_prev_rst, m_mem, m_mdu, m_err;
   int         m_age, m_stall, m_flush;
   bit         m_tmo, m_mem_blk, m_mdu_blk, m_redir;
   logic [6:0] m_ctl;

   always #5 clk = ~clk;

   assign ctl = {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold, mem_wb_flush};

   hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
      .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done), .mem_req(mem_req), .mem_ack(mem_ack),
      .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
      .id_ex_hold(id_ex_hold), .id_ex_flush(id_ex_flush), .ex_mem_hold(ex_mem_hold),
      .mem_wb_flush(mem_wb_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_err(mem_err)
   );

   function automatic stim_t mk(bit r, bit br, bit ms, bit md, bit mq, bit ma, bit mr,
                                logic [4:0] rd, logic [4:0] r1, bit u1, logic [4:0] r2, bit u2);
      stim_t s;
      s.rst = r; s.ex_br_taken = br; s.ex_mdu_start = ms; s.mdu_done = md;
      s.mem_req = mq; s.mem_ack = ma; s.ex_mem_read = mr; s.ex_rd = rd;
      s.id_rs1 = r1; s.id_use_rs1 = u1; s.id_rs2 = r2; s.id_use_rs2 = u2;
      return s;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at t=%0t", nm, got, want, $time);
      end
   endtask

   // Pipeline rules: memory wait outranks MDU wait, which outranks redirect, then load-use
   task automatic model_eval(input stim_t x);
      bit live, frozen, haz, ldu;
      live      = !x.rst && !m_prev_rst;
      m_tmo     = live && m_mem && !x.mem_ack && (m_age == TO - 1);
      m_mem_blk = live && !x.mem_ack && !m_tmo && (m_mem || (!m_mdu && x.mem_req));
      m_mdu_blk = live && !m_mem_blk && !x.mdu_done && (m_mdu || x.ex_mdu_start);
      frozen    = m_mem_blk || m_mdu_blk;
      haz       = x.ex_mem_read && (x.ex_rd != 5'd0) &&
                  ((x.id_use_rs1 && x.id_rs1 == x.ex_rd) || (x.id_use_rs2 && x.id_rs2 == x.ex_rd));
      m_redir   = live && x.ex_br_taken && !frozen;
      ldu       = live && haz && !frozen && !m_redir;
      m_ctl     = {frozen || ldu, frozen || ldu, m_redir, frozen, m_redir || ldu, m_mem_blk, m_mem_blk};
   endtask

   task automatic model_commit(input stim_t x);
      if (x.rst) begin
         m_mem = 0; m_mdu = 0; m_err = 0; m_age = 0; m_stall = 0; m_flush = 0;
      end else begin
         if (m_ctl[6]) m_stall = (m_stall + 1) % (1 << CW);
         if (m_redir)  m_flush = (m_flush + 1) % (1 << CW);
         if (m_tmo)    m_err = 1;
         m_age = (m_mem && m_mem_blk) ? m_age + 1 : 0;
         m_mem = m_mem_blk;
         m_mdu = m_mdu_blk;
      end
      m_prev_rst = x.rst;
   endtask

   // Called at posedge+1: drive, sample at negedge, advance model at posedge
   task automatic cycle(input stim_t s);
      rst = s.rst; id_rs1 = s.id_rs1; id_rs2 = s.id_rs2; id_use_rs1 = s.id_use_rs1;
      id_use_rs2 = s.id_use_rs2; ex_rd = s.ex_rd; ex_mem_read = s.ex_mem_read;
      ex_br_taken = s.ex_br_taken; ex_mdu_start = s.ex_mdu_start; mdu_done = s.mdu_done;
      mem_req = s.mem_req; mem_ack = s.mem_ack;
      @(negedge clk);
      model_eval(s);
      seen = ctl;
      chk("ctl_model", ctl, m_ctl);
      chk("stall_cnt_model", stall_cnt, m_stall);
      chk("flush_cnt_model", flush_cnt, m_flush);
      chk("mem_err_model", mem_err, m_err);
      @(posedge clk);
      model_commit(s);
      #1;
   endtask

   vec_t  vt[$];
   stim_t idle, ldu5;
   int    n, c0;
   bit    slow;

   initial begin
      idle = mk(0, 0,0,0, 0,0, 0, 5'd0, 5'd0,0, 5'd0,0);
      ldu5 = mk(0, 0,0,0, 0,0, 1, 5'd5, 5'd5,1, 5'd0,0);

      // Single-cycle cases evaluated from RUN: {stim, {pc,ifh,iff,idh,idf,exh,wbf}}
      vt.push_back('{ldu5,                                                 7'b1100100});
      vt.push_back('{mk(0, 0,0,0, 0,0, 1, 5'd0, 5'd0,1, 5'd0,1),          7'b0000000});
      vt.push_back('{mk(0, 0,0,0, 0,0, 1, 5'd7, 5'd1,1, 5'd7,1),          7'b1100100});
      vt.push_back('{mk(0, 0,0,0, 0,0, 1, 5'd7, 5'd7,0, 5'd7,0),          7'b0000000});
      vt.push_back('{mk(0, 0,0,0, 0,0, 0, 5'd9, 5'd9,1, 5'd9,1),          7'b0000000});
      vt.push_back('{mk(0, 1,0,0, 0,0, 0, 5'd0, 5'd0,0, 5'd0,0),          7'b0010100});
      vt.push_back('{mk(0, 1,0,0, 0,0, 1, 5'd5, 5'd5,1, 5'd0,0),          7'b0010100});
      vt.push_back('{mk(0, 0,0,0, 1,1, 0, 5'd0, 5'd0,0, 5'd0,0),          7'b0000000});
      vt.push_back('{mk(0, 0,0,0, 1,1, 1, 5'd3, 5'd2,1, 5'd3,1),          7'b1100100});
      vt.push_back('{mk(0, 0,1,1, 0,0, 0, 5'd0, 5'd0,0, 5'd0,0),          7'b0000000});
      vt.push_back('{idle,                                                 7'b0000000});

      // Power-up reset, then model aligned to the reset state
      rst = 1'b1; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_rd = 0;
      ex_mem_read = 0; ex_br_taken = 0; ex_mdu_start = 0; mdu_done = 0; mem_req = 0; mem_ack = 0;
      @(posedge clk); #1;
      m_prev_rst = 1; m_mem = 0; m_mdu = 0; m_err = 0; m_age = 0; m_stall = 0; m_flush = 0;

      // Reset cycle and the cycle after stay quiet even with a load-use present
      begin stim_t s; s = ldu5; s.rst = 1; cycle(s); end
      chk("rst_cycle_ctl", seen, 7'b0000000);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_flush_cnt", flush_cnt, 0);
      chk("rst_mem_err", mem_err, 0);
      cycle(ldu5);
      chk("post_rst_ctl", seen, 7'b0000000);
      cycle(ldu5);
      chk("ldu_first", seen, 7'b1100100);
      chk("ldu_stall_cnt", stall_cnt, 1);
      cycle(idle);

      foreach (vt[i]) begin
         cycle(vt[i].s);
         chk($sformatf("vec%0d", i), seen, vt[i].ctl);
      end
      chk("vec_flush_cnt", flush_cnt, 2);

      // MDU: done arrives on the fifth cycle
      c0 = stall_cnt; n = 0;
      for (int i = 0; i < 4; i++) begin
         cycle(mk(0, 0,1,0, 0,0, 0, 5'd0, 5'd0,0, 5'd0,0));
         if (seen == 7'b1101000) n++;
      end
      chk("mdu_hold_cycles", n, 4);
      cycle(mk(0, 0,1,1, 0,0, 0, 5'd0, 5'd0,0, 5'd0,0));
      chk("mdu_release", seen, 7'b0000000);
      chk("mdu_stall_delta", (stall_cnt - c0) & 8'hff, 4);
      cycle(idle);

      // MEM: ack arrives on the fourth cycle
      n = 0;
      for (int i = 0; i < 3; i++) begin
         cycle(mk(0, 0,0,0, 1,0, 0, 5'd0, 5'd0,0, 5'd0,0));
         if (seen == 7'b1101011) n++;
      end
      chk("mem_hold_cycles", n, 3);
      cycle(mk(0, 0,0,0, 1,1, 0, 5'd0, 5'd0,0, 5'd0,0));
      chk("mem_release", seen, 7'b0000000);

      // Redirect under a memory wait is deferred to the ack cycle
      c0 = flush_cnt;
      cycle(mk(0, 1,0,0, 1,0, 0, 5'd0, 5'd0,0, 5'd0,0));
      chk("mem_br_held", seen, 7'b1101011);
      cycle(mk(0, 1,0,0, 1,1, 0, 5'd0, 5'd0,0, 5'd0,0));
      chk("mem_br_release", seen, 7'b0010100);
      chk("mem_br_flush_delta", (flush_cnt - c0) & 8'hff, 1);
      cycle(idle);

      // Timeout: never ack
      n = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(mk(0, 0,0,0, 1,0, 0, 5'd0, 5'd0,0, 5'd0,0));
         if (seen[6]) n++;
         else break;
      end
      chk("tmo_hold_cycles", n, TO);
      chk("tmo_release_ctl", seen, 7'b0000000);
      cycle(idle);
      chk("tmo_mem_err_set", mem_err, 1);
      for (int i = 0; i < 4; i++) cycle(ldu5);
      chk("tmo_mem_err_sticky", mem_err, 1);
      begin stim_t s; s = idle; s.rst = 1; cycle(s); end
      chk("tmo_err_cleared", mem_err, 0);
      cycle(idle);

      // Reset in the middle of an MDU wait
      cycle(idle);
      for (int i = 0; i < 2; i++) cycle(mk(0, 0,1,0, 0,0, 0, 5'd0, 5'd0,0, 5'd0,0));
      begin stim_t s; s = mk(1, 0,1,0, 0,0, 0, 5'd0, 5'd0,0, 5'd0,0); cycle(s); end
      chk("rst_mdu_ctl", seen, 7'b0000000);
      chk("rst_mdu_stall_cnt", stall_cnt, 0);
      cycle(mk(0, 0,1,0, 0,0, 0, 5'd0, 5'd0,0, 5'd0,0));
      chk("post_rst_mdu_ctl", seen, 7'b0000000);
      cycle(idle);
      cycle(mk(0, 1,0,0, 0,0, 0, 5'd0, 5'd0,0, 5'd0,0));
      chk("rst_mdu_back_in_run", seen, 7'b0010100);

      // Random run against the model
      slow = 0;
      for (int i = 0; i < 3000; i++) begin
         stim_t s;
         if (i % 200 == 0) slow = ($urandom_range(0, 2) == 0);
         s.rst          = ($urandom_range(0, 249) == 0);
         s.ex_rd        = 5'($urandom_range(0, 3));
         s.id_rs1       = 5'($urandom_range(0, 3));
         s.id_rs2       = 5'($urandom_range(0, 3));
         s.id_use_rs1   = ($urandom_range(0, 1) == 1);
         s.id_use_rs2   = ($urandom_range(0, 1) == 1);
         s.ex_mem_read  = ($urandom_range(0, 1) == 1);
         s.ex_mdu_start = ($urandom_range(0, 9) == 0);
         s.mdu_done     = ($urandom_range(0, 3) == 0);
         s.ex_br_taken  = !s.ex_mdu_start && ($urandom_range(0, 5) == 0);
         s.mem_req      = m_mem || (!m_mdu && ($urandom_range(0, 4) == 0));
         s.mem_ack      = slow ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
         cycle(s);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
